t03_wishbone_arbiter_manager: RTL
=================================

Name: t03_wishbone_arbiter_manager

Overview:
Parametrised next-generation Wishbone classic master that lets NUM_CH requesters share one bus, e.g. instruction fetch and data memory unit.
- Arbitration is round-robin; one transaction is in flight at a time.
- Each channel has its own BUSY, DONE and registered read-data return.
- Sits between the CPU request ports and the Wishbone interconnect.

Parameters:
NUM_CH, 2, number of requester channels (>=1)
AW, 32, address width
DW, 32, data width; select width SW = DW/8 (derived localparam)
TIMEOUT_CYC, 256, bus cycles without ACK before abort (used only with optional feature)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
WRITE_I  in  NUM_CH  per-channel write request (level)
READ_I  in  NUM_CH  per-channel read request (level)
ADR_I  in  NUM_CH*AW  per-channel address, channel c at [c*AW +: AW]
CPU_DAT_I  in  NUM_CH*DW  per-channel write data
SEL_I  in  NUM_CH*SW  per-channel byte selects
CPU_DAT_O  out  NUM_CH*DW  per-channel registered read data
BUSY_O  out  NUM_CH  channel c's transaction is in flight
DONE_O  out  NUM_CH  one-cycle completion pulse
ERR_O  out  NUM_CH  one-cycle error pulse, coincident with DONE_O
GNT_O  out  max(1,clog2(NUM_CH))  index of the current/last granted channel
ADR_O  out  AW  Wishbone address
DAT_O  out  DW  Wishbone write data
SEL_O  out  SW  Wishbone byte select
WE_O  out  1  Wishbone write enable
STB_O  out  1  Wishbone strobe
CYC_O  out  1  Wishbone cycle
DAT_I  in  DW  Wishbone read data
ACK_I  in  1  Wishbone acknowledge

Behaviour:
- Reset values: all outputs registered and reset to 0. Internal last_grant resets to NUM_CH-1, so channel 0 has first priority.
- Valid request on channel c: WRITE_I[c] XOR READ_I[c]. Both high or both low means no request.
- A valid request on channel c is ignored in any cycle where DONE_O[c]=1. The requester must drop the request on DONE.
- State IDLE:
  - If any valid request exists, grant the first requesting channel searching upward from last_grant+1 with wrap.
  - At that edge latch the granted channel's ADR/SEL into ADR_O/SEL_O. Latch DAT_O = CPU_DAT_I for writes, 0 for reads.
  - Set WE_O = write, STB_O = CYC_O = 1, BUSY_O[g] = 1, GNT_O = g, last_grant = g. Go to BUS.
  - Latency: request sampled at edge k gives CYC/STB high after edge k.
- State BUS:
  - Bus outputs stay frozen; input changes on the granted channel are ignored.
  - On ACK_I=1: at that edge clear ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O and BUSY_O[g]. Pulse DONE_O[g] for one cycle. Go to IDLE.
  - If the transaction is a read, also capture DAT_I into CPU_DAT_O slot g.
  - A new grant is possible at the very next edge. A bus idle gap of one cycle is minimum.
- ACK_I while IDLE is ignored.
- CPU_DAT_O slot c holds its value until the next successful read on channel c. Writes never modify it.
- Non-granted requesters see BUSY_O=0 and must hold their request level until granted.
- Fairness: with all channels continuously requesting, grants rotate 0,1,...,NUM_CH-1,0. No channel waits more than NUM_CH-1 transactions.
- Reset mid-transaction asynchronously drops CYC/STB and all BUSY/DONE/ERR. Read data returns to 0.
- NUM_CH=1: arbiter degenerates; GNT_O is constant 0.

Optional Feature:
Macro T03_WB_TIMEOUT_EN.
- With the macro: a counter of width clog2(TIMEOUT_CYC+1) clears on entering BUS and increments each BUS cycle without ACK_I.
  - When it reaches TIMEOUT_CYC-1 without ACK, the next edge aborts: bus outputs clear as for ACK, DONE_O[g] and ERR_O[g] pulse.
  - For reads, CPU_DAT_O slot g is loaded with 32'hBAD1BAD1 replicated/truncated to DW.
  - ACK_I on the same cycle as the limit takes priority: normal completion, no error.
- Without the macro: no counter; BUS waits indefinitely; ERR_O is tied 0.

Test Plan:
- Single read, ch0 ADR=0x0000_1000 SEL=4'hF, slave ACKs 3 cycles after STB with DAT_I=0xDEADBEEF -> CYC/STB high 1 cycle after request, WE_O=0, CPU_DAT_O[0]=0xDEADBEEF, DONE_O[0] one pulse, BUSY_O[0] drops same edge.
- Single write, ch1 ADR=0x20 CPU_DAT_I=0x12345678 SEL=4'h3 -> WE_O=1, DAT_O=0x12345678, SEL_O=4'h3 until ACK; CPU_DAT_O[1] unchanged.
- Both channels request continuously for 6 transactions, immediate ACK -> GNT_O sequence 0,1,0,1,0,1; ch0 read data never corrupts ch1 slot.
- WRITE_I[0]=READ_I[0]=1 for 10 cycles -> no CYC_O, BUSY_O stays 0; ACK_I pulsed in IDLE -> no DONE_O.
- nRST asserted while CYC_O=1 -> all outputs 0 immediately; after release, channel 0 wins a simultaneous 2-channel request.
- With T03_WB_TIMEOUT_EN, TIMEOUT_CYC=8, read with no ACK -> abort after 8 BUS cycles, ERR_O[g]=DONE_O[g]=1 for one cycle, CPU_DAT_O slot=0xBAD1BAD1; repeat with ACK on 8th cycle -> no ERR.

Source files
------------

// File: rtl/t03_wishbone_arbiter_manager.sv
// Round-robin Wishbone classic master shared by NUM_CH requesters, one transaction in flight.
// Optional bus watchdog abort enabled with `define T03_WB_TIMEOUT_EN.
module t03_wishbone_arbiter_manager #(
    parameter int NUM_CH      = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 256,
    localparam int SW         = DW / 8,
    localparam int GW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NUM_CH-1:0]    WRITE_I,
    input  logic [NUM_CH-1:0]    READ_I,
    input  logic [NUM_CH*AW-1:0] ADR_I,
    input  logic [NUM_CH*DW-1:0] CPU_DAT_I,
    input  logic [NUM_CH*SW-1:0] SEL_I,
    output logic [NUM_CH*DW-1:0] CPU_DAT_O,
    output logic [NUM_CH-1:0]    BUSY_O,
    output logic [NUM_CH-1:0]    DONE_O,
    output logic [NUM_CH-1:0]    ERR_O,
    output logic [GW-1:0]        GNT_O,
    output logic [AW-1:0]        ADR_O,
    output logic [DW-1:0]        DAT_O,
    output logic [SW-1:0]        SEL_O,
    output logic                 WE_O,
    output logic                 STB_O,
    output logic                 CYC_O,
    input  logic [DW-1:0]        DAT_I,
    input  logic                 ACK_I
);

    typedef enum logic {
        IDLE,
        BUS
    } state_e;

    state_e              state_q;
    logic [GW-1:0]       lastGrant_q;
    logic [GW-1:0]       gnt_q;
    logic [AW-1:0]       adr_q;
    logic [DW-1:0]       dat_q;
    logic [SW-1:0]       sel_q;
    logic                we_q;
    logic                cyc_q;
    logic [NUM_CH-1:0]   busy_q;
    logic [NUM_CH-1:0]   done_q;
    logic [NUM_CH*DW-1:0] rdata_q;

    logic [NUM_CH-1:0]   reqValid_d;
    logic                hiFound_d;
    logic                loFound_d;
    logic [GW-1:0]       hiIdx_d;
    logic [GW-1:0]       loIdx_d;
    logic                anyReq_d;
    logic [GW-1:0]       pick_d;
    logic [NUM_CH-1:0]   pickOh_d;
    logic [AW-1:0]       pickAdr_d;
    logic [DW-1:0]       pickDat_d;
    logic [SW-1:0]       pickSel_d;
    logic                pickWe_d;

`ifdef T03_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int BADREPS = DW / 32 + 1;
    localparam logic [BADREPS*32-1:0] BADREP = {BADREPS{32'hBAD1BAD1}};
    localparam logic [DW-1:0] BADVAL = BADREP[DW-1:0];

    logic [CW-1:0]       tmoCnt_q;
    logic [NUM_CH-1:0]   err_q;
`endif

    // A channel that is being told DONE this cycle must not be re-granted on the same request.
    assign reqValid_d = (WRITE_I ^ READ_I) & ~done_q;

    // Round-robin: prefer channels above the last grant, otherwise wrap to the lowest requester.
    always_comb begin
        hiFound_d = 1'b0;
        loFound_d = 1'b0;
        hiIdx_d   = '0;
        loIdx_d   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (reqValid_d[c]) begin
                if (GW'(c) > lastGrant_q) begin
                    if (!hiFound_d) begin
                        hiFound_d = 1'b1;
                        hiIdx_d   = GW'(c);
                    end
                end else if (!loFound_d) begin
                    loFound_d = 1'b1;
                    loIdx_d   = GW'(c);
                end
            end
        end
        anyReq_d = hiFound_d | loFound_d;
        pick_d   = hiFound_d ? hiIdx_d : loIdx_d;
    end

    always_comb begin
        pickOh_d  = '0;
        pickAdr_d = '0;
        pickDat_d = '0;
        pickSel_d = '0;
        pickWe_d  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (GW'(c) == pick_d) begin
                pickOh_d[c] = 1'b1;
                pickAdr_d   = ADR_I[c*AW +: AW];
                pickSel_d   = SEL_I[c*SW +: SW];
                pickWe_d    = WRITE_I[c];
                pickDat_d   = WRITE_I[c] ? CPU_DAT_I[c*DW +: DW] : '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            lastGrant_q <= GW'(NUM_CH - 1);
            gnt_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            busy_q      <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
`ifdef T03_WB_TIMEOUT_EN
            tmoCnt_q    <= '0;
            err_q       <= '0;
`endif
        end else begin
            done_q <= '0;
`ifdef T03_WB_TIMEOUT_EN
            err_q  <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (anyReq_d) begin
                        state_q     <= BUS;
                        gnt_q       <= pick_d;
                        lastGrant_q <= pick_d;
                        adr_q       <= pickAdr_d;
                        dat_q       <= pickDat_d;
                        sel_q       <= pickSel_d;
                        we_q        <= pickWe_d;
                        cyc_q       <= 1'b1;
                        busy_q      <= pickOh_d;
`ifdef T03_WB_TIMEOUT_EN
                        tmoCnt_q    <= '0;
`endif
                    end
                end
                BUS: begin
                    if (ACK_I) begin
                        state_q <= IDLE;
                        adr_q   <= '0;
                        dat_q   <= '0;
                        sel_q   <= '0;
                        we_q    <= 1'b0;
                        cyc_q   <= 1'b0;
                        busy_q  <= '0;
                        done_q  <= busy_q;
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (busy_q[c] && !we_q) begin
                                rdata_q[c*DW +: DW] <= DAT_I;
                            end
                        end
                    end
`ifdef T03_WB_TIMEOUT_EN
                    // Abort once the limit cycle passes with no ACK; a late ACK above still wins.
                    else if (tmoCnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        state_q <= IDLE;
                        adr_q   <= '0;
                        dat_q   <= '0;
                        sel_q   <= '0;
                        we_q    <= 1'b0;
                        cyc_q   <= 1'b0;
                        busy_q  <= '0;
                        done_q  <= busy_q;
                        err_q   <= busy_q;
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (busy_q[c] && !we_q) begin
                                rdata_q[c*DW +: DW] <= BADVAL;
                            end
                        end
                    end else begin
                        tmoCnt_q <= tmoCnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CPU_DAT_O = rdata_q;
    assign BUSY_O    = busy_q;
    assign DONE_O    = done_q;
    assign GNT_O     = gnt_q;
    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign SEL_O     = sel_q;
    assign WE_O      = we_q;
    assign STB_O     = cyc_q;
    assign CYC_O     = cyc_q;
`ifdef T03_WB_TIMEOUT_EN
    assign ERR_O     = err_q;
`else
    assign ERR_O     = '0;
`endif

endmodule
